// File: rtl/otter_pkg.sv
// Shared types for the OTTER memory stage: access sizes, sequencer states, datapath width.
package otter_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for data memory: byte enables, store replication,
// alignment check and load extraction with sign/zero extension.
module dmem_lane_align
    import otter_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic              zext,
    input  logic [WORD_W-1:0] wdata_in,
    input  logic [WORD_W-1:0] rdata_in,
    output logic [3:0]        be,
    output logic [WORD_W-1:0] wdata_out,
    output logic [WORD_W-1:0] rdata_out,
    output logic              misalign
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata_in[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata_in[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        be        = 4'b0000;
        wdata_out = wdata_in;
        rdata_out = rdata_in;
        misalign  = 1'b0;
        case (mem_size_t'(size))
            BYTE: begin
                be        = 4'b0001 << addr_lo;
                wdata_out = {4{wdata_in[7:0]}};
                rdata_out = {{24{byte_sel[7] & ~zext}}, byte_sel};
            end
            HALF: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_out = {2{wdata_in[15:0]}};
                rdata_out = {{16{half_sel[15] & ~zext}}, half_sel};
                misalign  = addr_lo[0];
            end
            WORD: begin
                be       = 4'b1111;
                misalign = |addr_lo;
            end
            default: begin
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_stage_ctrl.sv
// Memory-stage sequencer: issues data-memory requests, stalls the pipeline
// until the access completes or times out, and returns extended load data.
//
// Bus handshake: DMEM_REQ is valid, DMEM_GNT is ready; a request transfers in
// the cycle both are high, and ADDR/BE/WDATA/WE hold stable while REQ waits.
// A read then completes in the first cycle DMEM_RVALID is high.
module dmem_stage_ctrl
    import otter_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              ValidM,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [WORD_W-1:0] ALUResultM,
    input  logic [WORD_W-1:0] WriteDataM,
    input  logic [1:0]        MemSizeM,
    input  logic              MemSignM,
    output logic              DMEM_REQ,
    output logic              DMEM_WE,
    output logic [WORD_W-1:0] DMEM_ADDR,
    output logic [3:0]        DMEM_BE,
    output logic [WORD_W-1:0] DMEM_WDATA,
    input  logic              DMEM_GNT,
    input  logic              DMEM_RVALID,
    input  logic [WORD_W-1:0] DMEM_RDATA,
    output logic              StallM,
    output logic [WORD_W-1:0] ReadDataM,
    output logic              MisalignM,
    output logic              TimeoutM,
    output logic [1:0]        dbg_state
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    dmem_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic              we_q, we_d;

    logic              access, is_wr, bad, start;
    logic [WORD_W-1:0] sel_addr, sel_wdata;
    logic [1:0]        sel_size;
    logic              sel_sign, sel_we;
    logic [3:0]        lane_be;
    logic [WORD_W-1:0] lane_wdata, lane_rdata;

    logic              req, done, stall, mis, tmo;
    logic [WORD_W-1:0] rd_out;

    // Load wins when both read and write are flagged.
    assign is_wr  = MemWriteM & ~MemReadM;
    assign access = ValidM & (MemReadM | MemWriteM);
    assign start  = access & ~bad;

    // IDLE issues straight from the pipeline register; later states replay the latched copy.
    always_comb begin
        if (state_q == IDLE) begin
            sel_addr  = ALUResultM;
            sel_wdata = WriteDataM;
            sel_size  = MemSizeM;
            sel_sign  = MemSignM;
            sel_we    = is_wr;
        end else begin
            sel_addr  = addr_q;
            sel_wdata = wdata_q;
            sel_size  = size_q;
            sel_sign  = sign_q;
            sel_we    = we_q;
        end
    end

    dmem_lane_align u_align (
        .addr_lo   (sel_addr[1:0]),
        .size      (sel_size),
        .zext      (sel_sign),
        .wdata_in  (sel_wdata),
        .rdata_in  (DMEM_RDATA),
        .be        (lane_be),
        .wdata_out (lane_wdata),
        .rdata_out (lane_rdata),
        .misalign  (bad)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sign_d  = sign_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        rd_out  = rdata_q;
        req     = 1'b0;
        done    = 1'b0;
        stall   = 1'b0;
        mis     = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            IDLE: begin
                mis = access & bad;
                if (mis) begin
                    rdata_d = '0;
                    rd_out  = '0;
                end
                if (start) begin
                    addr_d  = ALUResultM;
                    wdata_d = WriteDataM;
                    size_d  = MemSizeM;
                    sign_d  = MemSignM;
                    we_d    = is_wr;
                    req     = 1'b1;
                    if (DMEM_GNT) begin
                        if (is_wr) begin
                            done = 1'b1;
                        end else begin
                            state_d = RESP;
                            cnt_d   = '0;
                        end
                    end else begin
                        state_d = REQ;
                        cnt_d   = '0;
                    end
                    stall = ~done;
                end
            end
            REQ: begin
                req = 1'b1;
                if (DMEM_GNT) begin
                    if (we_q) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    tmo     = 1'b1;
                    state_d = IDLE;
                    rdata_d = '0;
                    rd_out  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                stall = ~done & ~tmo;
            end
            RESP: begin
                if (DMEM_RVALID) begin
                    done    = 1'b1;
                    state_d = IDLE;
                    rdata_d = lane_rdata;
                    rd_out  = lane_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    tmo     = 1'b1;
                    state_d = IDLE;
                    rdata_d = '0;
                    rd_out  = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                stall = ~done & ~tmo;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            we_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
        end
    end

    // Control outputs are forced low while reset is asserted, even from the combinational IDLE path.
    assign DMEM_REQ   = RST_N & req;
    assign DMEM_WE    = RST_N & req & sel_we;
    assign DMEM_ADDR  = {sel_addr[WORD_W-1:2], 2'b00};
    assign DMEM_BE    = lane_be;
    assign DMEM_WDATA = lane_wdata;
    assign StallM     = RST_N & stall;
    assign MisalignM  = RST_N & mis;
    assign TimeoutM   = RST_N & tmo;
    assign ReadDataM  = RST_N ? rd_out : '0;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_stage_ctrl.sv
// Randomized scoreboard bench for dmem_stage_ctrl with a bus-level reference model.
module tb_dmem_stage_ctrl;

  localparam int TMO = 8;
  localparam int EXP_W = 119;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        ValidM, MemReadM, MemWriteM, MemSignM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [1:0]  MemSizeM;
  logic        DMEM_REQ, DMEM_WE, DMEM_GNT, DMEM_RVALID;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
  logic [3:0]  DMEM_BE;
  logic        StallM, MisalignM, TimeoutM;
  logic [31:0] ReadDataM;
  logic [1:0]  dbg_state;

  dmem_stage_ctrl #(.TIMEOUT(TMO), .CNT_W(7)) dut (
    .CLK(CLK), .RST_N(RST_N), .ValidM(ValidM), .MemReadM(MemReadM),
    .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .MemSizeM(MemSizeM), .MemSignM(MemSignM), .DMEM_REQ(DMEM_REQ),
    .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR), .DMEM_BE(DMEM_BE),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_GNT(DMEM_GNT), .DMEM_RVALID(DMEM_RVALID),
    .DMEM_RDATA(DMEM_RDATA), .StallM(StallM), .ReadDataM(ReadDataM),
    .MisalignM(MisalignM), .TimeoutM(TimeoutM), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [31:0] last_rd;
  logic txn_active = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    ValidM = 0; MemReadM = 0; MemWriteM = 0; MemSignM = 0;
    ALUResultM = 0; WriteDataM = 0; MemSizeM = 0;
    DMEM_GNT = 0; DMEM_RVALID = 0; DMEM_RDATA = 0;
  endtask

  // Driver: presents one M-stage instruction, plays the memory, pushes the expected outcome.
  // Called at posedge+1; returns at posedge+1 after the completion cycle.
  task automatic do_access(input bit ld, input bit st, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [1:0] sz, input bit sgn,
                           input bit vld, input int d, input int rv, input logic [31:0] rword);
    int a, k, stall_e, req_e;
    bit mem, bad, good, mis_e, tmo_e, we_e;
    logic [31:0] be_m, wd_m, rd_m, sh;
    a = int'(addr[1:0]);
    mem = ld | st;
    bad = (sz == 2'd3) || (sz == 2'd1 && (a % 2) == 1) || (sz == 2'd2 && a != 0);
    good = vld && mem && !bad;
    mis_e = vld && mem && bad;
    we_e = st && !ld;
    tmo_e = 0; stall_e = 0; req_e = 0; rd_m = last_rd;
    case (sz)
      2'd0: begin be_m = 32'(1 << a); wd_m = (wd & 32'hFF) * 32'h0101_0101; end
      2'd1: begin be_m = 32'(3 << a); wd_m = (wd & 32'hFFFF) * 32'h0001_0001; end
      default: begin be_m = 32'hF; wd_m = wd; end
    endcase
    if (mis_e) rd_m = 0;
    if (good) begin
      req_e = d + 1;
      if (!ld) stall_e = d;
      else if (rv < 0 || rv > TMO - 1) begin
        stall_e = d + TMO; tmo_e = 1; rd_m = 0;
      end else begin
        stall_e = d + 1 + rv;
        sh = rword >> (8 * a);
        if (sz == 2'd0) rd_m = (sh & 32'hFF) | ((!sgn && sh[7]) ? 32'hFFFF_FF00 : 32'h0);
        else if (sz == 2'd1) rd_m = (sh & 32'hFFFF) | ((!sgn && sh[15]) ? 32'hFFFF_0000 : 32'h0);
        else rd_m = rword;
      end
    end
    last_rd = rd_m;
    exp_q.push_back({rd_m, mis_e, tmo_e, 8'(stall_e), 8'(req_e), we_e, be_m[3:0],
                     addr & 32'hFFFF_FFFC, wd_m});
    ValidM = vld; MemReadM = ld; MemWriteM = st; ALUResultM = addr;
    WriteDataM = wd; MemSizeM = sz; MemSignM = sgn; DMEM_RDATA = rword;
    txn_active = 1;
    k = 0;
    forever begin
      DMEM_GNT = good && (k == d);
      DMEM_RVALID = good && ld && rv >= 0 && (k == d + 1 + rv);
      @(negedge CLK); #1;
      if (!StallM) break;
      if (k > 200) begin
        n_cmp++; n_fail++;
        $display("FAIL stall_bound: StallM still 1 after %0d cycles, required completion", k);
        break;
      end
      @(posedge CLK); #1;
      k++;
    end
    @(posedge CLK); #1;
    txn_active = 0;
    idle_inputs();
  endtask

  // Monitor: checks every request cycle and pops one expectation per completed instruction.
  int stall_cnt = 0, req_cnt = 0, mis_cnt = 0, tmo_cnt = 0;
  always @(negedge CLK) begin
    logic [EXP_W-1:0] e;
    if (RST_N && txn_active) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL no_expect: DUT activity with empty queue at %0t", $time);
      end else begin
        e = exp_q[0];
        if (DMEM_REQ) begin
          req_cnt++;
          check("req_fields", {59'd0, DMEM_WE, DMEM_BE, DMEM_ADDR, DMEM_WDATA}, {59'd0, e[68:0]});
        end
        mis_cnt += int'(MisalignM);
        tmo_cnt += int'(TimeoutM);
        if (StallM) stall_cnt++;
        else begin
          e = exp_q.pop_front();
          check("read_data", 128'(ReadDataM), 128'(e[118:87]));
          check("misalign_pulses", 128'(mis_cnt), 128'(e[86]));
          check("timeout_pulses", 128'(tmo_cnt), 128'(e[85]));
          check("stall_cycles", 128'(stall_cnt), 128'(e[84:77]));
          check("req_cycles", 128'(req_cnt), 128'(e[76:69]));
          stall_cnt = 0; req_cnt = 0; mis_cnt = 0; tmo_cnt = 0;
        end
      end
    end
  end

  initial begin
    idle_inputs();
    last_rd = 0;
    RST_N = 0;
    // a valid store presented during reset must not leak onto the bus
    ValidM = 1; MemWriteM = 1; MemSizeM = 2'd2; ALUResultM = 32'h100; DMEM_GNT = 1;
    #12;
    check("reset_outputs", {121'd0, DMEM_REQ, DMEM_WE, StallM, MisalignM, TimeoutM, 2'b00},
          128'd0);
    check("reset_rdata", 128'(ReadDataM), 128'd0);
    idle_inputs();
    @(negedge CLK); RST_N = 1;
    @(posedge CLK); #1;

    // directed cases
    do_access(0, 1, 32'h100, 32'hDEAD_BEEF, 2'd2, 0, 1, 0, 0, 32'h0);
    do_access(1, 0, 32'h103, 32'h0, 2'd0, 0, 1, 0, 0, 32'h80FF_FFFF);
    do_access(1, 0, 32'h103, 32'h0, 2'd0, 1, 1, 0, 0, 32'h80FF_FFFF);
    do_access(0, 1, 32'h102, 32'h1234_ABCD, 2'd1, 0, 1, 3, 0, 32'h0);
    do_access(1, 0, 32'h101, 32'h0, 2'd2, 0, 1, 0, 0, 32'h0);
    do_access(1, 0, 32'h101, 32'h0, 2'd2, 0, 0, 0, 0, 32'h0);
    do_access(1, 0, 32'h040, 32'h0, 2'd2, 0, 1, 0, -1, 32'h0);
    do_access(0, 1, 32'h044, 32'h5555_AAAA, 2'd2, 0, 1, 1, 0, 32'h0);
    do_access(1, 1, 32'h046, 32'h0, 2'd1, 0, 1, 2, TMO - 1, 32'h8001_7FFF);

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      bit ld, vld;
      int rv;
      ld = $urandom_range(0, 1);
      vld = ($urandom_range(0, 9) != 0);
      rv = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 3));
      do_access(ld, !ld, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                vld, int'($urandom_range(0, 4)), rv, $urandom);
    end

    // asynchronous reset in the middle of a read response wait
    ValidM = 1; MemReadM = 1; MemSizeM = 2'd2; ALUResultM = 32'h300; DMEM_GNT = 1;
    @(posedge CLK); #1;
    DMEM_GNT = 0;
    @(negedge CLK); #1;
    check("resp_stall_before_reset", 128'(StallM), 128'd1);
    #1 RST_N = 0;
    #1;
    check("async_reset_req", 128'(DMEM_REQ), 128'd0);
    check("async_reset_stall", 128'(StallM), 128'd0);
    check("async_reset_rdata", 128'(ReadDataM), 128'd0);
    idle_inputs();
    last_rd = 0;
    @(negedge CLK); RST_N = 1;
    @(posedge CLK); #1;
    do_access(1, 0, 32'h200, 32'h0, 2'd1, 0, 1, 1, 1, 32'h1234_F00D);
    do_access(0, 1, 32'h204, 32'hCAFE_0001, 2'd0, 0, 1, 0, 0, 32'h0);

    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_stage_ctrl.md
Name: dmem_stage_ctrl

Overview:
- Memory-stage sequencer for the pipelined OTTER core. Sits between the E-to-M pipeline register outputs and the data-memory bus.
- Issues load/store transactions over a request/grant/response handshake and builds byte enables and lane-aligned write data.
- Holds the pipeline via StallM until the access completes, then returns aligned, sign/zero-extended load data to the M-to-W register.

Parameters:
- TIMEOUT, 64, cycles allowed in REQ or RESP before the access is abandoned (>=2).
- CNT_W, 7, width of the timeout counter; must hold TIMEOUT.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- ValidM  in  1  M-stage holds a real instruction (not a bubble)
- MemReadM  in  1  instruction is a load
- MemWriteM  in  1  instruction is a store
- ALUResultM  in  32  effective byte address
- WriteDataM  in  32  store data, right-justified
- MemSizeM  in  2  00 byte, 01 half, 10 word, 11 illegal
- MemSignM  in  1  1 = zero-extend load (LBU/LHU), 0 = sign-extend
- DMEM_REQ  out  1  request valid
- DMEM_WE  out  1  request is a write
- DMEM_ADDR  out  32  word address {addr[31:2],2'b00}
- DMEM_BE  out  4  byte enables
- DMEM_WDATA  out  32  lane-replicated write data
- DMEM_GNT  in  1  request accepted this cycle
- DMEM_RVALID  in  1  read data valid
- DMEM_RDATA  in  32  raw read word
- StallM  out  1  freeze F/D/E/M pipeline registers
- ReadDataM  out  32  extended load result
- MisalignM  out  1  one-cycle pulse: misaligned or illegal-size access suppressed
- TimeoutM  out  1  one-cycle pulse: access abandoned

Behaviour:
- start = ValidM & (MemReadM | MemWriteM) & ~bad. bad = size 11, half with addr[0]=1, or word with addr[1:0]!=0. If MemReadM and MemWriteM are both high, treat as a load.
- FSM states:
  - IDLE: on start, drive DMEM_REQ combinationally.
    - GNT with write: done, no stall.
    - GNT with read: go to RESP.
    - no GNT: go to REQ.
    - Latch address, size, sign and write flag on every start.
  - REQ: DMEM_REQ=1 from latched fields.
    - GNT: write goes to IDLE (done); read goes to RESP.
  - RESP: DMEM_REQ=0.
    - RVALID: capture read data, go to IDLE (done).
- StallM = (IDLE & start & ~done) | (REQ & ~done) | (RESP & ~RVALID). StallM is low in the completion cycle.
- Minimum latency:
  - write with immediate GNT: 0 stall cycles.
  - read with GNT, then RVALID next cycle: 1 stall cycle.
- ReadDataM is combinational from DMEM_RDATA in the RVALID cycle and registered-held afterwards.
  - Shift right by addr[1:0]*8, then extend: byte from bit 7, half from bit 15, or zero-extend per MemSignM. Word passes through unchanged.
- DMEM_BE:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<{addr[1],1'b0}
  - word: 4'b1111
- DMEM_WDATA: byte replicated x4, half replicated x2, word unchanged.
- Bad access: MisalignM=1 for that cycle, no request, no stall, ReadDataM=0. A bad access on a bubble (ValidM=0) produces no pulse.
- Timeout:
  - Counter clears on entering REQ or RESP and increments each cycle there.
  - At count==TIMEOUT-1 without completion: TimeoutM pulse, go to IDLE, StallM low, ReadDataM=0.
  - A late RVALID/GNT while in IDLE is ignored.
- DMEM_REQ, once asserted, holds with stable ADDR/BE/WDATA/WE until GNT.
- Reset, asynchronous, any state (including mid-transaction): state=IDLE, counter=0, ReadDataM register=0.
  - All outputs are 0 while RST_N=0, except ADDR/BE/WDATA, which are don't-care with REQ=0.

Decomposition:
- Shared package (otter_pkg):
  - mem_size_t enum (BYTE, HALF, WORD, ILLEGAL)
  - dmem_state_t enum (IDLE, REQ, RESP)
  - WORD_W=32
- Sub-module dmem_lane_align: purely combinational. Computes BE, WDATA replication, misalign detection and load extraction/extension. The FSM stays in the top level.

Test Plan:
- SW 0xDEADBEEF to 0x100, GNT same cycle -> REQ=1, WE=1, BE=1111, ADDR=0x100, StallM=0 throughout.
- LB from 0x103, RDATA=0x80FF_FF_FF, GNT cycle 0, RVALID cycle 1 -> StallM high 1 cycle, ReadDataM=0xFFFFFF80; same with MemSignM=1 -> 0x00000080.
- SH 0x1234_ABCD to 0x102, GNT delayed 3 cycles -> BE=1100, WDATA=0xABCDABCD held stable through REQ, StallM high 3 cycles.
- LW at 0x101 -> MisalignM pulse, REQ=0, StallM=0; same with ValidM=0 -> no pulse.
- LW, GNT given, RVALID never comes, TIMEOUT=8 -> StallM high 8 cycles, TimeoutM one pulse, FSM IDLE, next store issues normally.
- Assert RST_N=0 while in RESP -> REQ, StallM drop immediately (asynchronous); after release, a new LH at 0x200 completes correctly.
